// File: rtl/bank_isu_issue_queue_if.sv
// bank_isu_issue_queue_if: groups the signals between the hit/tag unit, the linefill buffer,
// the SRAM controller and the credit return path for one bank issue queue.
// The slave modport is the queue itself. The master modport is the surrounding environment.
interface bank_isu_issue_queue_if #(
  parameter int NUM_CH = 4,
  parameter int ROB_W  = 3,
  parameter int SWO_W  = 7,
  parameter int WBID_W = 8,
  parameter int LF_DW  = 256
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Enqueue side (hit/tag unit)
  logic              req_valid;
  logic              req_allow_in;
  logic              req_inflight;
  logic              req_linefill;
  logic [1:0]        req_opcode;
  logic [ROB_W-1:0]  req_rob_id;
  logic [CH_W-1:0]   req_ch_id;
  logic [SWO_W-1:0]  req_swo;
  logic [WBID_W-1:0] req_wbid;
  logic [3:0]        req_state;

  // Linefill wakeup and linefill-buffer read port
  logic              refill_valid;
  logic [SWO_W-2:0]  refill_id;
  logic [SWO_W-2:0]  lfb_raddr;
  logic [LF_DW-1:0]  lfb_data;

  // Issue side (SRAM controller)
  logic              sc_valid;
  logic              sc_ready;
  logic [2:0]        sc_opcode;
  logic [CH_W-1:0]   sc_ch_id;
  logic [ROB_W-1:0]  sc_rob_id;
  logic [SWO_W-1:0]  sc_swo;
  logic [WBID_W-1:0] sc_wbid;
  logic [3:0]        sc_state;
  logic [LF_DW/2-1:0] sc_lf_data0;
  logic [LF_DW/2-1:0] sc_lf_data1;

  // Per-channel read credit return
  logic [NUM_CH-1:0] credit_release;

  modport slave (
    input  req_valid, req_inflight, req_linefill, req_opcode, req_rob_id, req_ch_id,
           req_swo, req_wbid, req_state, refill_valid, refill_id, lfb_data, sc_ready,
           credit_release,
    output req_allow_in, lfb_raddr, sc_valid, sc_opcode, sc_ch_id, sc_rob_id, sc_swo,
           sc_wbid, sc_state, sc_lf_data0, sc_lf_data1
  );

  modport master (
    output req_valid, req_inflight, req_linefill, req_opcode, req_rob_id, req_ch_id,
           req_swo, req_wbid, req_state, refill_valid, refill_id, lfb_data, sc_ready,
           credit_release,
    input  req_allow_in, lfb_raddr, sc_valid, sc_opcode, sc_ch_id, sc_rob_id, sc_swo,
           sc_wbid, sc_state, sc_lf_data0, sc_lf_data1
  );
endinterface

// File: rtl/bank_isu_issue_queue.sv
// bank_isu_issue_queue: bank issue queue between the hit/tag unit and the SRAM controller.
// In-order enqueue, oldest-ready out-of-order issue, in-order retire, per-channel read credits,
// linefill wakeup merged into the enqueue cycle.
// Optional feature macro: ISU_IQ_STALL_CNT_EN adds saturating credit/mshr stall counters.
module bank_isu_issue_queue #(
  parameter int PTR_WIDTH = 4,
  parameter int NUM_CH    = 4,
  parameter int CREDITS   = 4,
  parameter int ROB_W     = 3,
  parameter int SWO_W     = 7,
  parameter int WBID_W    = 8,
  parameter int LF_DW     = 256
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  bank_isu_issue_queue_if.slave bus
`ifdef ISU_IQ_STALL_CNT_EN
  ,
  output logic [31:0]           stall_credit_cnt_o,
  output logic [31:0]           stall_mshr_cnt_o
`endif
);
  localparam int DEPTH = 2 ** PTR_WIDTH;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CNT_W = $clog2(CREDITS + 1);

  typedef struct packed {
    logic              write;
    logic              linefill;
    logic [ROB_W-1:0]  rob_id;
    logic [CH_W-1:0]   ch_id;
    logic [SWO_W-1:0]  swo;
    logic [WBID_W-1:0] wbid;
    logic [3:0]        state;
  } entry_t;

  logic [PTR_WIDTH-1:0] wptr, bptr, sel;
  logic [PTR_WIDTH:0]   count;
  logic [DEPTH-1:0]     valid_q, mshr_q, evict_q;
  logic [DEPTH-1:0]     is_read, line_hit, exec;
  entry_t               mem [DEPTH];
  entry_t               sel_e;
  logic [CNT_W-1:0]     credit_q [NUM_CH];
  logic [NUM_CH-1:0]    credit_take;
  logic                 found, allow_in, fire, issue, retire, enq_mshr, sel_read;

  // Per-entry readiness: line data present (or eviction due first) and a read credit if needed.
  always_comb begin
    // NOTE: every signal written here gets a default before any condition, so no latch is inferred.
    is_read  = '0;
    line_hit = '0;
    exec     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      is_read[i]  = ~mem[i].write & ~evict_q[i];
      line_hit[i] = bus.refill_valid & (mem[i].swo[SWO_W-1:1] == bus.refill_id);
      exec[i]     = valid_q[i] & (mshr_q[i] | evict_q[i])
                  & (~is_read[i] | (credit_q[mem[i].ch_id] != '0));
    end
  end

  // Oldest-first pick: scan upward from the bottom pointer with wrap; the first exec entry wins.
  always_comb begin
    logic [PTR_WIDTH-1:0] idx;
    found = 1'b0;
    sel   = bptr;
    idx   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = bptr + PTR_WIDTH'(k);
      // NOTE: blocking assignments let 'found' carry between iterations, giving a priority chain.
      if (!found && exec[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  assign sel_e    = mem[sel];
  assign sel_read = is_read[sel];
  assign allow_in = (count != (PTR_WIDTH + 1)'(DEPTH));
  assign fire     = bus.req_valid & allow_in;
  assign issue    = found & bus.sc_ready;
  assign retire   = (count != '0) & ~valid_q[bptr];
  assign enq_mshr = ~(bus.req_linefill | bus.req_inflight)
                  | (bus.refill_valid & (bus.refill_id == bus.req_swo[SWO_W-1:1]));

  assign bus.req_allow_in = allow_in;
  assign bus.sc_valid     = found;
  assign bus.sc_opcode    = evict_q[sel] ? 3'd3 : sel_e.write ? 3'd0 : sel_e.linefill ? 3'd2 : 3'd1;
  assign bus.sc_ch_id     = sel_e.ch_id;
  assign bus.sc_rob_id    = sel_e.rob_id;
  assign bus.sc_swo       = sel_e.swo;
  assign bus.sc_wbid      = sel_e.wbid;
  assign bus.sc_state     = sel_e.state;
  assign bus.lfb_raddr    = sel_e.swo[SWO_W-1:1];
  assign bus.sc_lf_data0  = bus.lfb_data[LF_DW/2-1:0];
  assign bus.sc_lf_data1  = bus.lfb_data[LF_DW-1:LF_DW/2];

  // Pointers, occupancy and per-entry status bits; enqueue overrides wakeup/issue on the wptr slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr    <= '0;
      bptr    <= '0;
      count   <= '0;
      valid_q <= '0;
      mshr_q  <= '0;
      evict_q <= '0;
    end else begin
      if (fire)   wptr <= wptr + PTR_WIDTH'(1);
      if (retire) bptr <= bptr + PTR_WIDTH'(1);
      if (fire && !retire)      count <= count + (PTR_WIDTH + 1)'(1);
      else if (!fire && retire) count <= count - (PTR_WIDTH + 1)'(1);
      mshr_q <= mshr_q | (valid_q & line_hit);
      if (issue) begin
        if (evict_q[sel]) evict_q[sel] <= 1'b0;
        else              valid_q[sel] <= 1'b0;
      end
      if (fire) begin
        valid_q[wptr] <= 1'b1;
        mshr_q[wptr]  <= enq_mshr;
        evict_q[wptr] <= bus.req_opcode[1];
      end
    end
  end

  // Payload storage, written on enqueue only.
  always_ff @(posedge clk_i) begin
    // NOTE: payload has no reset; valid_q guards every use, so stale contents are never observed.
    if (fire) begin
      mem[wptr] <= '{write:    bus.req_opcode[0],
                     linefill: bus.req_linefill,
                     rob_id:   bus.req_rob_id,
                     ch_id:    bus.req_ch_id,
                     swo:      bus.req_swo,
                     wbid:     bus.req_wbid,
                     state:    bus.req_state};
    end
  end

  // Which channel spends a read credit this cycle (evict and write issues never do).
  always_comb begin
    credit_take = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      credit_take[c] = issue & sel_read & (sel_e.ch_id == CH_W'(c));
    end
  end

  // Per-channel credit counters: spend on read issue, refund on release, net zero when both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NUM_CH; c++) credit_q[c] <= CNT_W'(CREDITS);
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (bus.credit_release[c] && !credit_take[c])      credit_q[c] <= credit_q[c] + CNT_W'(1);
        else if (!bus.credit_release[c] && credit_take[c]) credit_q[c] <= credit_q[c] - CNT_W'(1);
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_credit_chk
    a_release_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(bus.credit_release[c] && (credit_q[c] == CNT_W'(CREDITS))));
    a_issue_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(credit_take[c] && (credit_q[c] == '0)));
  end

`ifdef ISU_IQ_STALL_CNT_EN
  logic [DEPTH-1:0] data_ok;
  logic             credit_stall, mshr_stall;

  assign data_ok      = valid_q & (mshr_q | evict_q);
  assign credit_stall = (|valid_q) & ((valid_q & ~(data_ok & ~exec)) == '0);
  assign mshr_stall   = (|valid_q) & ~found & (|(valid_q & ~(mshr_q | evict_q)));

  // Saturating stall-cycle counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_credit_cnt_o <= '0;
      stall_mshr_cnt_o   <= '0;
    end else begin
      if (credit_stall && (stall_credit_cnt_o != '1)) stall_credit_cnt_o <= stall_credit_cnt_o + 32'd1;
      if (mshr_stall && (stall_mshr_cnt_o != '1))     stall_mshr_cnt_o   <= stall_mshr_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bank_isu_issue_queue.sv
// tb_bank_isu_issue_queue: scoreboard bench for bank_isu_issue_queue.
// A reference model keeps the queue as an age-ordered list; each cycle it predicts the
// outputs and pushes them to a queue that an independent monitor pops and compares.
module tb_bank_isu_issue_queue;
  localparam int PTR_WIDTH = 4;
  localparam int DEPTH     = 16;
  localparam int NUM_CH    = 4;
  localparam int CREDITS   = 4;
  localparam int ROB_W     = 3;
  localparam int SWO_W     = 7;
  localparam int WBID_W    = 8;
  localparam int LF_DW     = 256;

  typedef struct {
    logic [ROB_W-1:0]  rob;
    logic [1:0]        ch;
    logic [SWO_W-1:0]  swo;
    logic [WBID_W-1:0] wbid;
    logic [3:0]        state;
    bit                write;
    bit                lf;
    bit                evict;
    bit                mshr_ok;
    bit                done;
  } ment_t;

  typedef struct {
    bit                 valid;
    bit                 allow;
    logic [2:0]         op;
    logic [1:0]         ch;
    logic [ROB_W-1:0]   rob;
    logic [SWO_W-1:0]   swo;
    logic [WBID_W-1:0]  wbid;
    logic [3:0]         state;
    logic [SWO_W-2:0]   raddr;
    logic [LF_DW/2-1:0] d0;
    logic [LF_DW/2-1:0] d1;
  } exp_t;

  logic clk, rst_n;
  int   n_pass = 0;
  int   n_total = 0;

  ment_t mq[$];
  exp_t  exp_q[$];
  int    credit[NUM_CH];

  bank_isu_issue_queue_if #(.NUM_CH(NUM_CH), .ROB_W(ROB_W), .SWO_W(SWO_W),
                            .WBID_W(WBID_W), .LF_DW(LF_DW)) bus ();

`ifdef ISU_IQ_STALL_CNT_EN
  logic [31:0] stall_credit_cnt, stall_mshr_cnt;
`endif

  bank_isu_issue_queue #(.PTR_WIDTH(PTR_WIDTH), .NUM_CH(NUM_CH), .CREDITS(CREDITS),
                         .ROB_W(ROB_W), .SWO_W(SWO_W), .WBID_W(WBID_W), .LF_DW(LF_DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
`ifdef ISU_IQ_STALL_CNT_EN
    ,
    .stall_credit_cnt_o (stall_credit_cnt),
    .stall_mshr_cnt_o   (stall_mshr_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Linefill buffer stand-in: the read data is a recognisable function of the address.
  function automatic logic [LF_DW-1:0] lfb_word(input logic [SWO_W-2:0] a);
    return {{4{32'hABCD_0000 | 32'(a)}}, {4{32'h1234_0000 | 32'(a)}}};
  endfunction

  assign bus.lfb_data = lfb_word(bus.lfb_raddr);

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    mq.delete();
    for (int c = 0; c < NUM_CH; c++) credit[c] = CREDITS;
  endtask

  task automatic idle_inputs();
    bus.req_valid      = 1'b0;
    bus.req_inflight   = 1'b0;
    bus.req_linefill   = 1'b0;
    bus.req_opcode     = 2'b00;
    bus.req_rob_id     = '0;
    bus.req_ch_id      = '0;
    bus.req_swo        = '0;
    bus.req_wbid       = '0;
    bus.req_state      = '0;
    bus.refill_valid   = 1'b0;
    bus.refill_id      = '0;
    bus.credit_release = '0;
  endtask

  task automatic req(input logic [1:0] op, input bit lf, input bit infl, input int ch, input int line);
    bus.req_valid    = 1'b1;
    bus.req_opcode   = op;
    bus.req_linefill = lf;
    bus.req_inflight = infl;
    bus.req_ch_id    = 2'(ch);
    bus.req_rob_id   = ROB_W'($urandom);
    bus.req_swo      = {6'(line), 1'($urandom)};
    bus.req_wbid     = WBID_W'($urandom);
    bus.req_state    = 4'($urandom);
  endtask

  // One cycle: predict this cycle's outputs, advance the model across the edge, then clear pulses.
  task automatic tick();
    exp_t e;
    int   sel;
    bit   retire;
    logic [LF_DW-1:0] w;
    e = '{default: 0};
    e.allow = (mq.size() != DEPTH);
    sel = -1;
    for (int i = 0; i < mq.size(); i++) begin
      if (sel < 0 && !mq[i].done && (mq[i].mshr_ok || mq[i].evict) &&
          (mq[i].write || mq[i].evict || credit[mq[i].ch] > 0)) sel = i;
    end
    e.valid = (sel >= 0);
    if (e.valid) begin
      e.op    = mq[sel].evict ? 3'd3 : mq[sel].write ? 3'd0 : mq[sel].lf ? 3'd2 : 3'd1;
      e.ch    = mq[sel].ch;
      e.rob   = mq[sel].rob;
      e.swo   = mq[sel].swo;
      e.wbid  = mq[sel].wbid;
      e.state = mq[sel].state;
      e.raddr = mq[sel].swo[SWO_W-1:1];
      w       = lfb_word(e.raddr);
      e.d0    = w[LF_DW/2-1:0];
      e.d1    = w[LF_DW-1:LF_DW/2];
    end
    exp_q.push_back(e);

    retire = (mq.size() > 0) && mq[0].done;
    if (e.valid && bus.sc_ready) begin
      if (mq[sel].evict) mq[sel].evict = 0;
      else begin
        mq[sel].done = 1;
        if (!mq[sel].write) credit[mq[sel].ch]--;
      end
    end
    for (int c = 0; c < NUM_CH; c++) if (bus.credit_release[c]) credit[c]++;
    if (bus.refill_valid) begin
      for (int i = 0; i < mq.size(); i++)
        if (!mq[i].done && mq[i].swo[SWO_W-1:1] == bus.refill_id) mq[i].mshr_ok = 1;
    end
    if (retire) void'(mq.pop_front());
    if (bus.req_valid && e.allow) begin
      ment_t n;
      n.rob     = bus.req_rob_id;
      n.ch      = bus.req_ch_id;
      n.swo     = bus.req_swo;
      n.wbid    = bus.req_wbid;
      n.state   = bus.req_state;
      n.write   = bus.req_opcode[0];
      n.evict   = bus.req_opcode[1];
      n.lf      = bus.req_linefill;
      n.done    = 0;
      n.mshr_ok = !(bus.req_linefill || bus.req_inflight) ||
                  (bus.refill_valid && bus.refill_id == bus.req_swo[SWO_W-1:1]);
      mq.push_back(n);
    end
    @(negedge clk);
    bus.req_valid      = 1'b0;
    bus.refill_valid   = 1'b0;
    bus.credit_release = '0;
  endtask

  task automatic rand_cycle();
    bit w, ev, lf, infl;
    w    = ($urandom % 2) == 1;
    ev   = ($urandom % 8) == 0;
    lf   = !w && (($urandom % 4) == 0);
    infl = !lf && (($urandom % 8) == 0);
    if (($urandom % 3) != 0) req({ev, w}, lf, infl, int'($urandom % NUM_CH), int'($urandom % 8));
    bus.refill_valid = ($urandom % 4) == 0;
    bus.refill_id    = 6'($urandom % 8);
    bus.sc_ready     = ($urandom % 4) != 0;
    for (int c = 0; c < NUM_CH; c++)
      bus.credit_release[c] = (credit[c] < CREDITS) && (($urandom % 3) == 0);
    tick();
  endtask

  task automatic restore_credits();
    for (int r = 0; r < CREDITS; r++) begin
      for (int c = 0; c < NUM_CH; c++) bus.credit_release[c] = credit[c] < CREDITS;
      tick();
    end
  endtask

  // Monitor: pops one prediction per cycle and compares it with what the DUT presents.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sc_valid", 256'(bus.sc_valid), 256'(e.valid));
        check("allow_in", 256'(bus.req_allow_in), 256'(e.allow));
        if (e.valid && bus.sc_valid) begin
          check("opcode", 256'(bus.sc_opcode), 256'(e.op));
          check("ch_id", 256'(bus.sc_ch_id), 256'(e.ch));
          check("rob_id", 256'(bus.sc_rob_id), 256'(e.rob));
          check("swo", 256'(bus.sc_swo), 256'(e.swo));
          check("wbid", 256'(bus.sc_wbid), 256'(e.wbid));
          check("state", 256'(bus.sc_state), 256'(e.state));
          check("lfb_raddr", 256'(bus.lfb_raddr), 256'(e.raddr));
          check("lf_data0", 256'(bus.sc_lf_data0), 256'(e.d0));
          check("lf_data1", 256'(bus.sc_lf_data1), 256'(e.d1));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    bus.sc_ready = 1'b0;
    model_reset();
    #1;
    check("reset_sc_valid", 256'(bus.sc_valid), 256'(0));
    check("reset_allow_in", 256'(bus.req_allow_in), 256'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Four hit reads on ch0 drain its credits; the fifth waits for a release.
    bus.sc_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req(2'b00, 0, 0, 0, 1);
      tick();
    end
    repeat (4) tick();
    bus.credit_release = 4'b0001;
    tick();
    repeat (3) tick();

    // Miss A on line 5 then hit B: B first, A after the refill with opcode 2.
    req(2'b00, 1, 0, 1, 5);
    tick();
    req(2'b00, 0, 0, 1, 9);
    tick();
    repeat (3) tick();
    bus.refill_valid = 1'b1;
    bus.refill_id    = 6'd5;
    tick();
    repeat (3) tick();

    // Evict + read: writeback first, then the read.
    req(2'b10, 0, 0, 2, 3);
    tick();
    repeat (4) tick();

    // Fill the queue, issue one, retire it, enqueue into the wrapped slot, then drain.
    bus.sc_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      req(2'b01, 0, 0, int'($urandom % NUM_CH), int'($urandom % 8));
      tick();
    end
    bus.sc_ready = 1'b1;
    tick();
    bus.sc_ready = 1'b0;
    tick();
    tick();
    req(2'b01, 0, 0, 1, 6);
    tick();
    bus.sc_ready = 1'b1;
    repeat (DEPTH + 4) tick();

    // Miss enqueued in the same cycle its line lands.
    req(2'b00, 1, 0, 3, 7);
    bus.refill_valid = 1'b1;
    bus.refill_id    = 6'd7;
    tick();
    repeat (3) tick();

    restore_credits();

    for (int i = 0; i < 1500; i++) rand_cycle();

    // Asynchronous reset in the middle of traffic.
    #3;
    rst_n = 1'b0;
    #1;
    check("midreset_sc_valid", 256'(bus.sc_valid), 256'(0));
    check("midreset_allow_in", 256'(bus.req_allow_in), 256'(1));
    model_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;

    bus.sc_ready = 1'b1;
    for (int i = 0; i < CREDITS; i++) begin
      req(2'b00, 0, 0, 0, 2);
      tick();
    end
    repeat (3) tick();
    restore_credits();

    for (int i = 0; i < 400; i++) rand_cycle();

    idle_inputs();
    repeat (2) @(negedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
